univ_shift_reg: RTL and testbench

- Parametrised universal register, the next generation of the single-bit D flip-flop.
- Generalised to WIDTH bits, with hold, parallel load and left/right shift modes.
- Optional rotate, serial in and out, and an autonomous burst-shift engine that shifts N times and reports done.
- Used as the storage/serialiser primitive in the flipflop lab designs.

---
 rtl/univ_shift_pkg.sv | 20 ++
 rtl/univ_shift_reg_if.sv | 30 +++
 rtl/univ_shift_reg_shift_step.sv | 32 +++
 rtl/univ_shift_reg.sv | 88 ++++++++
 tb/tb_univ_shift_reg.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_pkg.sv
// Shared constants for the universal shift register: direct-mode encodings and
// burst FSM states.
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_mode(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg; the driver uses master, the register
// itself uses slave.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);

  logic             en;
  logic [1:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [CNT_W-1:0] nshift;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin, d, start, nshift,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, mode, sin, d, start, nshift,
    output q, sout_r, sout_l, busy, done
  );

endinterface

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational next-value function: hold, shift right/left or load, with the
// vacated bit filled from sin or, when rotating, from the bit shifted out.
module univ_shift_reg_shift_step
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ROTATE = 1'b0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic fill_r;
  logic fill_l;

  always_comb begin
    fill_r = ROTATE ? q_i[0]       : sin_i;
    fill_l = ROTATE ? q_i[WIDTH-1] : sin_i;
    q_o    = q_i;
    unique case (mode_i)
      MODE_HOLD: q_o = q_i;
      MODE_SHR:  q_o = {fill_r, q_i[WIDTH-1:1]};
      MODE_SHL:  q_o = {q_i[WIDTH-2:0], fill_l};
      MODE_LOAD: q_o = d_i;
      default:   q_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: direct hold/shift/load when idle, plus a burst
// engine that shifts nshift times in a captured direction and pulses done.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 4,
  parameter bit          ROTATE = 1'b0
) (
  input logic               clk,
  input logic               rst,
  univ_shift_reg_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       step_mode;

  // One datapath shared by direct mode and the burst engine; step_mode picks who drives it.
  univ_shift_reg_shift_step #(
    .WIDTH  (WIDTH),
    .ROTATE (ROTATE)
  ) u_step (
    .q_i    (q_q),
    .d_i    (bus.d),
    .mode_i (step_mode),
    .sin_i  (bus.sin),
    .q_o    (q_d)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    step_mode = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dir_d   = bus.mode;
          cnt_d   = bus.nshift;
          state_d = ((bus.nshift != '0) && is_shift_mode(bus.mode)) ? ST_SHIFT : ST_DONE;
        end else if (bus.en) begin
          step_mode = bus.mode;
        end
      end
      ST_SHIFT: begin
        step_mode = dir_q;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= MODE_HOLD;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench: a fill-from-sin instance (u0) and a rotating instance (u1)
// share one stimulus stream; each step checks hand-computed values.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sin;
  logic [7:0] d;
  logic       start;
  logic [3:0] nshift;

  int vecs;
  int errs;

  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) if0 ();
  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) if1 ();

  assign if0.en = en;  assign if0.mode = mode;  assign if0.sin = sin;
  assign if0.d = d;    assign if0.start = start; assign if0.nshift = nshift;
  assign if1.en = en;  assign if1.mode = mode;  assign if1.sin = sin;
  assign if1.d = d;    assign if1.start = start; assign if1.nshift = nshift;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4), .ROTATE(1'b0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  univ_shift_reg #(.WIDTH(8), .CNT_W(4), .ROTATE(1'b1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] seq;
    logic       prev_q6;
    vecs = 0;
    errs = 0;
    rst = 1'b0; en = 1'b0; mode = 2'b00; sin = 1'b0; d = 8'h00; start = 1'b0; nshift = 4'd0;
    tick();

    // Reset overrides a loaded value
    rst = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF;
    tick();
    check("preload_ff", 32'(if0.q), 32'h0000_00FF);
    en = 1'b0; rst = 1'b0;
    tick();
    check("rst_q0", 32'(if0.q), 32'h0);
    check("rst_q1", 32'(if1.q), 32'h0);
    check("rst_busy", 32'(if0.busy), 32'h0);
    check("rst_done", 32'(if0.done), 32'h0);
    check("rst_sout_r", 32'(if0.sout_r), 32'h0);
    check("rst_sout_l", 32'(if0.sout_l), 32'h0);
    rst = 1'b1;

    // Load, hold, disabled
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    tick();
    check("load_a5", 32'(if0.q), 32'hA5);
    mode = 2'b00;
    tick(); tick(); tick();
    check("hold_a5", 32'(if0.q), 32'hA5);
    en = 1'b0; mode = 2'b11; d = 8'h3C;
    tick();
    check("en0_a5", 32'(if0.q), 32'hA5);

    // Direct shifts
    en = 1'b1; mode = 2'b01; sin = 1'b1;
    tick();
    check("shr_sin1", 32'(if0.q), 32'hD2);
    check("shr_rot", 32'(if1.q), 32'hD2);
    mode = 2'b11; d = 8'hA5;
    tick();
    mode = 2'b10; sin = 1'b0;
    tick();
    check("shl_sin0", 32'(if0.q), 32'h4A);
    check("shl_rot", 32'(if1.q), 32'h4B);

    // Rotate burst of 3 with stray start pulses in SHIFT and DONE
    mode = 2'b11; d = 8'h81;
    tick();
    en = 1'b0; mode = 2'b01; nshift = 4'd3; start = 1'b1;
    tick();
    check("b_k_busy", 32'(if1.busy), 32'h1);
    check("b_k_q", 32'(if1.q), 32'h81);
    start = 1'b1; mode = 2'b10; nshift = 4'd5;
    tick();
    check("b_k1_q", 32'(if1.q), 32'hC0);
    check("b_k1_busy", 32'(if1.busy), 32'h1);
    start = 1'b0; mode = 2'b01;
    tick();
    check("b_k2_q", 32'(if1.q), 32'h60);
    check("b_k2_busy", 32'(if1.busy), 32'h1);
    tick();
    check("b_k3_q", 32'(if1.q), 32'h30);
    check("b_k3_busy", 32'(if1.busy), 32'h0);
    check("b_k3_done", 32'(if1.done), 32'h1);
    check("b_k3_q0", 32'(if0.q), 32'h10);
    start = 1'b1; nshift = 4'd3;
    tick();
    start = 1'b0;
    check("b_k4_done", 32'(if1.done), 32'h0);
    check("b_k4_busy", 32'(if1.busy), 32'h0);
    check("b_k4_q", 32'(if1.q), 32'h30);
    tick();
    check("b_k5_done", 32'(if1.done), 32'h0);
    check("b_k5_busy", 32'(if1.busy), 32'h0);

    // Zero-length burst
    mode = 2'b01; nshift = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done", 32'(if1.done), 32'h1);
    check("z_busy", 32'(if1.busy), 32'h0);
    check("z_q", 32'(if1.q), 32'h30);
    tick();
    check("z_done_clr", 32'(if1.done), 32'h0);
    check("z_q_after", 32'(if1.q), 32'h30);

    // Full-width rotate returns to start value
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    tick();
    en = 1'b0; mode = 2'b10; nshift = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("r8_busy", 32'(if1.busy), 32'h1);
    tick();
    check("r8_done", 32'(if1.done), 32'h1);
    check("r8_q", 32'(if1.q), 32'hA5);
    tick();

    // Reset mid-burst aborts with no done
    mode = 2'b01; nshift = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mr_busy", 32'(if1.busy), 32'h1);
    rst = 1'b0;
    tick();
    check("mr_q1", 32'(if1.q), 32'h0);
    check("mr_q0", 32'(if0.q), 32'h0);
    check("mr_busy0", 32'(if1.busy), 32'h0);
    check("mr_done0", 32'(if1.done), 32'h0);
    rst = 1'b1;
    tick();
    check("mr_done1", 32'(if1.done), 32'h0);
    check("mr_busy1", 32'(if1.busy), 32'h0);
    tick();
    check("mr_done2", 32'(if1.done), 32'h0);

    // Serial stream into the fill-from-sin instance
    seq = 8'b1011_0010;
    mode = 2'b10; nshift = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin = seq[7-i];
      prev_q6 = if0.q[6];
      tick();
      check($sformatf("ser_sout_l_%0d", i), 32'(if0.sout_l), 32'(prev_q6));
    end
    check("ser_done", 32'(if0.done), 32'h1);
    check("ser_q", 32'(if0.q), 32'hB2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
